// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: master drives Start and operands,
// slave returns Busy/Done and the registered difference (plus Ovf under SERIAL_SUB_OVF_EN).
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_in;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] diff;
  logic             B_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output Start, A, B, B_in,
`ifdef SERIAL_SUB_OVF_EN
    input  Ovf,
`endif
    input  Busy, Done, diff, B_out
  );

  modport slave (
    input  Start, A, B, B_in,
`ifdef SERIAL_SUB_OVF_EN
    output Ovf,
`endif
    output Busy, Done, diff, B_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - B_in, LSB first; Done pulses WIDTH+1 cycles after an accepted Start.
// Start is ignored (not queued) while Busy; SERIAL_SUB_OVF_EN adds a registered signed-overflow flag Ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             bor;
  logic [CW-1:0]    cnt;

  logic             start_acc;
  logic             last_bit;
  logic             d_bit;
  logic             bor_nxt;

  logic [WIDTH-1:0] diff_q;
  logic             b_out_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  assign start_acc = bus.Start && (state != SHIFT);
  assign last_bit  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  assign d_bit   = a_sr[0] ^ b_sr[0] ^ bor;
  assign bor_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & bor) | (b_sr[0] & bor);
  // Result fills from the top; the final bit completes it without an extra shift.
  assign res_nxt = {d_bit, res_sr};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.Start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else if (start_acc) begin
      a_sr   <= bus.A;
      b_sr   <= bus.B;
      res_sr <= '0;
      bor    <= bus.B_in;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt[WIDTH-1:1];
      bor    <= bor_nxt;
      cnt    <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  // Outputs move only on the completing edge, so partial results never show.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      diff_q  <= '0;
      b_out_q <= 1'b0;
    end else if (last_bit) begin
      diff_q  <= res_nxt;
      b_out_q <= bor_nxt;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // On the last bit a_sr[0]/b_sr[0] hold the operand MSBs and d_bit is the result MSB.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d_bit);
    end
  end

  assign bus.Ovf = ovf_q;
`endif

  assign bus.Busy  = (state == SHIFT);
  assign bus.Done  = (state == DONE);
  assign bus.diff  = diff_q;
  assign bus.B_out = b_out_q;
endmodule
